filter_channel_scheduler: RTL and testbench
===========================================

Name: filter_channel_scheduler

Overview:
Time-multiplexes one single-stream adaptive filter core between N_CH independent sample channels.
- Input side: round-robin arbitration of channel requests onto the core's ready/valid input.
- Output side: each core result is routed back to its originating channel using an in-order tag FIFO.
- Drain/halt FSM: lets software quiesce the core, with nothing in flight, before coefficient reload or mode changes.
- Placement: directly in front of and behind the filter core in the filter subsystem.

Parameters:
N_CH, 4, number of requesting channels (2..16)
DATA_WIDTH, 16, sample width, signed Q1.15, passed through unmodified
TAG_DEPTH, 8, max samples in flight inside the core; must be ≥ core pipeline depth + 1; power of 2
TAG_W, $clog2(N_CH), channel tag width (derived localparam)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
ch_in_valid  in  N_CH  per-channel sample valid
ch_in_ready  out  N_CH  per-channel accept
ch_in_data  in  N_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
core_in_valid  out  1  to core
core_in_ready  in  1  from core
core_in_data  out  DATA_WIDTH  granted sample
core_out_valid  in  1  core result valid
core_out_ready  out  1  backpressure to core
core_out_data  in  DATA_WIDTH  core result
ch_out_valid  out  N_CH  per-channel result valid
ch_out_ready  in  N_CH  per-channel result accept
ch_out_data  out  DATA_WIDTH  shared result bus; meaningful only where ch_out_valid is set
cfg_enable  in  1  level; start scheduling
cfg_halt  in  1  level; request drain and halt
sts_halted  out  1  high in HALTED state
sts_inflight  out  $clog2(TAG_DEPTH)+1  tag FIFO occupancy
err_orphan  out  1  sticky; core result arrived with tag FIFO empty

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, rr_ptr=0, FIFO empty, err_orphan=0.
  - All outputs 0 during and after reset until a state or input change. ch_out_data=0 while no valid.
- FSM, transitions evaluated in this priority order:
  - cfg_enable=0 in any state → IDLE next cycle; FIFO contents retained; outputs still drain.
  - IDLE → RUN when cfg_enable=1.
  - RUN → DRAIN when cfg_halt=1.
  - DRAIN → HALTED when occupancy=0 and no pop this cycle.
  - HALTED → RUN when cfg_halt=0.
- Issue (combinational, zero latency):
  - Allowed only in RUN with registered occupancy < TAG_DEPTH. No full-and-pop bypass.
  - Grant = first i with ch_in_valid[i]=1, searching cyclically from rr_ptr.
  - core_in_valid=1 and core_in_data=ch_in_data[grant]; ch_in_ready[grant]=core_in_ready; all other ch_in_ready=0.
  - On handshake: push grant tag; rr_ptr ← (grant+1) mod N_CH.
  - No handshake: rr_ptr unchanged.
- Return path:
  - head = FIFO head tag.
  - When FIFO non-empty: ch_out_valid[head]=core_out_valid, ch_out_data=core_out_data, core_out_ready=ch_out_ready[head].
  - Pop on core_out_valid & core_out_ready.
  - FIFO empty: core_out_ready=1; any core_out_valid is dropped and sets err_orphan (cleared only by rst).
- Simultaneous push and pop: occupancy unchanged; both pointers advance, wrapping mod TAG_DEPTH.
- Ordering: results return in issue order; per-channel order preserved.
- cfg_halt rising in the same cycle as a grant: the grant still completes (combinational issue decided from the current state); DRAIN begins next cycle.
- Reset mid-operation: FIFO cleared. The core shares rst, so no orphans are expected after reset.

Optional Feature:
SCHED_WEIGHTED_EN
- Defined:
  - Adds input cfg_weight (N_CH*4 bits).
  - Channel i may take up to cfg_weight[i]+1 consecutive grants before rr_ptr advances.
  - A per-grant burst counter resets when the grant moves or the channel deasserts valid.
- Undefined: pure round-robin as above; no extra ports.

Test Plan:
- N_CH=4, all channels valid continuously, core_in_ready=1, cfg_enable=1 → grants 0,1,2,3,0,… one per cycle; core returns identity after 3 cycles → each ch_out sees its own samples in order.
- Only ch2 valid, data 0x1234 → ch2 granted every cycle; rr_ptr=3 after each; ch_out_valid[2] only, data routed correctly.
- Core backpressure until occupancy=8 → core_in_valid=0, all ch_in_ready=0, sts_inflight=8. One pop → issue resumes next cycle.
- cfg_halt=1 with 5 in flight → no new grants; sts_halted=1 one cycle after the 5th pop. cfg_halt=0 → RUN and grants resume.
- ch_out_ready[1]=0 while head tag=1 → core_out_ready=0 and the core stalls; release → pop.
- Inject core_out_valid with FIFO empty → err_orphan=1 sticky until rst; data not routed to any channel.

Source files
------------

// File: rtl/filter_channel_scheduler.sv
// filter_channel_scheduler
//   Shares one single-stream filter core between N_CH sample channels.
//   Input side: round-robin grant of channel samples onto the core input.
//   Output side: an in-order tag FIFO steers each core result back to the
//   channel that issued it.
//   Drain/halt FSM: software can quiesce the core with nothing in flight.
//
// Optional build macro: SCHED_WEIGHTED_EN
//   When defined, adds i_cfg_weight. Channel i may then take up to
//   i_cfg_weight[4*i +: 4] + 1 back-to-back grants before the round-robin
//   pointer moves past it.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_ch_in_valid       per-channel sample valid              [N_CH]
//   o_ch_in_ready       per-channel accept                    [N_CH]
//   i_ch_in_data        channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   o_core_in_valid     sample to core valid
//   i_core_in_ready     core accepts sample
//   o_core_in_data      granted sample
//   i_core_out_valid    core result valid
//   o_core_out_ready    backpressure to core
//   i_core_out_data     core result
//   o_ch_out_valid      per-channel result valid              [N_CH]
//   i_ch_out_ready      per-channel result accept             [N_CH]
//   o_ch_out_data       shared result bus (0 when no valid)
//   i_cfg_enable        level; scheduling enabled
//   i_cfg_halt          level; drain and halt request
//   o_sts_halted        high in HALTED
//   o_sts_inflight      tag FIFO occupancy
//   o_err_orphan        sticky; core result seen with no tag outstanding
module filter_channel_scheduler #(
    parameter int N_CH       = 4,
    parameter int DATA_WIDTH = 16,
    parameter int TAG_DEPTH  = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
`ifdef SCHED_WEIGHTED_EN
    input  logic [N_CH*4-1:0]            i_cfg_weight,
`endif
    input  logic [N_CH-1:0]              i_ch_in_valid,
    output logic [N_CH-1:0]              o_ch_in_ready,
    input  logic [N_CH*DATA_WIDTH-1:0]   i_ch_in_data,
    output logic                         o_core_in_valid,
    input  logic                         i_core_in_ready,
    output logic [DATA_WIDTH-1:0]        o_core_in_data,
    input  logic                         i_core_out_valid,
    output logic                         o_core_out_ready,
    input  logic [DATA_WIDTH-1:0]        i_core_out_data,
    output logic [N_CH-1:0]              o_ch_out_valid,
    input  logic [N_CH-1:0]              i_ch_out_ready,
    output logic [DATA_WIDTH-1:0]        o_ch_out_data,
    input  logic                         i_cfg_enable,
    input  logic                         i_cfg_halt,
    output logic                         o_sts_halted,
    output logic [$clog2(TAG_DEPTH):0]   o_sts_inflight,
    output logic                         o_err_orphan
);

    localparam int TAG_W = $clog2(N_CH);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_HALTED} state_t;

    state_t              r_state, w_state_nxt;
    logic [TAG_W-1:0]    r_rr_ptr;
    logic [TAG_W-1:0]    r_tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]    r_wptr, r_rptr;
    logic [CNT_W-1:0]    r_count;
    logic                r_err_orphan;

    logic                w_any;
    logic [TAG_W-1:0]    w_grant;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                w_empty, w_full;
    logic                w_in_valid, w_push, w_pop, w_orphan;
    logic [TAG_W-1:0]    w_head;

    // (p + k) mod N_CH for k < N_CH; N_CH need not be a power of 2
    function automatic logic [TAG_W-1:0] f_wrap(input logic [TAG_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N_CH) s = s - N_CH;
        return TAG_W'(s);
    endfunction

    // ---------------- round-robin grant ----------------
    always_comb begin
        w_any   = 1'b0;
        w_grant = r_rr_ptr;
        for (int k = 0; k < N_CH; k++) begin
            if (!w_any && i_ch_in_valid[f_wrap(r_rr_ptr, k)]) begin
                w_any   = 1'b1;
                w_grant = f_wrap(r_rr_ptr, k);
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (TAG_W'(i) == w_grant) w_sel_data = i_ch_in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(TAG_DEPTH));

    // Issue is decided purely from registered state: a full FIFO blocks
    // issue even if a result is popped in the same cycle.
    assign w_in_valid = (r_state == S_RUN) && !w_full && w_any;
    assign w_push     = w_in_valid && i_core_in_ready;

    assign o_core_in_valid = w_in_valid;
    assign o_core_in_data  = w_in_valid ? w_sel_data : '0;

    always_comb begin
        o_ch_in_ready = '0;
        if (w_in_valid) o_ch_in_ready[w_grant] = i_core_in_ready;
    end

    // ---------------- return path ----------------
    assign w_head   = r_tag_mem[r_rptr];
    assign w_pop    = !w_empty && i_core_out_valid && i_ch_out_ready[w_head];
    // With no tag outstanding the result has no owner: accept and drop it.
    assign w_orphan = w_empty && i_core_out_valid;

    always_comb begin
        o_ch_out_valid   = '0;
        o_ch_out_data    = '0;
        o_core_out_ready = 1'b1;
        if (!w_empty) begin
            o_ch_out_valid[w_head] = i_core_out_valid;
            o_core_out_ready       = i_ch_out_ready[w_head];
            if (i_core_out_valid) o_ch_out_data = i_core_out_data;
        end
    end

    // ---------------- FSM ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (!i_cfg_enable) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   w_state_nxt = S_RUN;
                S_RUN:    if (i_cfg_halt) w_state_nxt = S_DRAIN;
                S_DRAIN:  if (w_empty && !w_pop) w_state_nxt = S_HALTED;
                S_HALTED: if (!i_cfg_halt) w_state_nxt = S_RUN;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // ---------------- tag FIFO ----------------
    always_ff @(posedge i_clk) begin
        if (w_push) r_tag_mem[r_wptr] <= w_grant;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_orphan) r_err_orphan <= 1'b1;
        end
    end

    // ---------------- round-robin pointer ----------------
`ifdef SCHED_WEIGHTED_EN
    logic [3:0]       r_burst;
    logic [TAG_W-1:0] r_burst_ch;
    logic [3:0]       w_weight_g;
    logic [3:0]       w_cur_burst;

    always_comb begin
        w_weight_g = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (TAG_W'(i) == w_grant) w_weight_g = i_cfg_weight[i*4 +: 4];
        end
    end

    // A burst only continues while the same channel keeps winning.
    assign w_cur_burst = (w_grant == r_burst_ch) ? r_burst : 4'd0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr   <= '0;
            r_burst    <= '0;
            r_burst_ch <= '0;
        end else if (w_push) begin
            if (w_cur_burst >= w_weight_g) begin
                r_rr_ptr <= f_wrap(w_grant, 1);
                r_burst  <= '0;
            end else begin
                r_rr_ptr   <= w_grant;
                r_burst    <= w_cur_burst + 4'd1;
                r_burst_ch <= w_grant;
            end
        end else if (!i_ch_in_valid[r_burst_ch]) begin
            r_burst <= '0;
        end
    end
`else
    always_ff @(posedge i_clk) begin
        if (i_rst)       r_rr_ptr <= '0;
        else if (w_push) r_rr_ptr <= f_wrap(w_grant, 1);
    end
`endif

    assign o_sts_halted   = (r_state == S_HALTED);
    assign o_sts_inflight = r_count;
    assign o_err_orphan   = r_err_orphan;

endmodule

// File: tb/tb_filter_channel_scheduler.sv
module tb_filter_channel_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ch_in_valid, ch_in_ready;
    logic [63:0] ch_in_data;
    logic        core_in_valid, core_in_ready;
    logic [15:0] core_in_data;
    logic        core_out_valid, core_out_ready;
    logic [15:0] core_out_data;
    logic [3:0]  ch_out_valid, ch_out_ready;
    logic [15:0] ch_out_data;
    logic        cfg_enable, cfg_halt, sts_halted, err_orphan;
    logic [3:0]  sts_inflight;

    int n_tests = 0;
    int n_fail  = 0;

    filter_channel_scheduler #(.N_CH(4), .DATA_WIDTH(16), .TAG_DEPTH(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_ch_in_valid(ch_in_valid), .o_ch_in_ready(ch_in_ready), .i_ch_in_data(ch_in_data),
        .o_core_in_valid(core_in_valid), .i_core_in_ready(core_in_ready), .o_core_in_data(core_in_data),
        .i_core_out_valid(core_out_valid), .o_core_out_ready(core_out_ready), .i_core_out_data(core_out_data),
        .o_ch_out_valid(ch_out_valid), .i_ch_out_ready(ch_out_ready), .o_ch_out_data(ch_out_data),
        .i_cfg_enable(cfg_enable), .i_cfg_halt(cfg_halt),
        .o_sts_halted(sts_halted), .o_sts_inflight(sts_inflight), .o_err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1; ch_in_valid = 0; ch_in_data = 0; core_in_ready = 0;
        core_out_valid = 0; core_out_data = 0; ch_out_ready = 0;
        cfg_enable = 0; cfg_halt = 0;
        tick(); tick();
        #1;
        // reset state
        chk("rst_core_in_valid", core_in_valid, 0);
        chk("rst_ch_in_ready",   ch_in_ready, 0);
        chk("rst_core_in_data",  core_in_data, 0);
        chk("rst_ch_out_valid",  ch_out_valid, 0);
        chk("rst_ch_out_data",   ch_out_data, 0);
        chk("rst_halted",        sts_halted, 0);
        chk("rst_inflight",      sts_inflight, 0);
        chk("rst_orphan",        err_orphan, 0);
        tick();
        rst = 0;

        // IDLE: no issue even with requests pending
        cfg_enable = 1; ch_in_valid = 4'hF; core_in_ready = 1; ch_out_ready = 4'hF;
        #1;
        chk("idle_no_issue", core_in_valid, 0);
        chk("idle_no_ready", ch_in_ready, 0);
        tick();

        // A: all channels valid, core returns each sample 3 cycles later
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 4; i++) ch_in_data[i*16 +: 16] = 16'((c << 8) | i);
            if (c >= 3) begin
                core_out_valid = 1;
                core_out_data  = 16'(((c - 3) << 8) | ((c - 3) % 4));
            end else begin
                core_out_valid = 0;
            end
            #1;
            chk("A_core_in_valid", core_in_valid, 1);
            chk("A_grant",         ch_in_ready, 1 << (c % 4));
            chk("A_core_in_data",  core_in_data, (c << 8) | (c % 4));
            chk("A_inflight",      sts_inflight, (c < 3) ? c : 3);
            if (c >= 3) begin
                chk("A_ch_out_valid", ch_out_valid, 1 << ((c - 3) % 4));
                chk("A_ch_out_data",  ch_out_data, ((c - 3) << 8) | ((c - 3) % 4));
            end
            tick();
        end
        ch_in_valid = 0;
        for (int d = 0; d < 3; d++) begin
            core_out_valid = 1;
            core_out_data  = 16'(((5 + d) << 8) | ((5 + d) % 4));
            #1;
            chk("A_drain_valid", ch_out_valid, 1 << ((5 + d) % 4));
            chk("A_drain_data",  ch_out_data, ((5 + d) << 8) | ((5 + d) % 4));
            chk("A_drain_cordy", core_out_ready, 1);
            tick();
        end
        core_out_valid = 0;
        #1;
        chk("A_empty", sts_inflight, 0);

        // B: only ch2 valid
        ch_in_valid = 4'b0100;
        ch_in_data[2*16 +: 16] = 16'h1234;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("B_grant", ch_in_ready, 4'b0100);
            chk("B_data",  core_in_data, 16'h1234);
            tick();
        end
        // rr_ptr must now be 3: with 0,2,3 requesting, ch3 wins
        ch_in_valid = 4'b1101; core_in_ready = 0;
        ch_in_data[3*16 +: 16] = 16'h3333;
        ch_in_data[0*16 +: 16] = 16'h0000;
        #1;
        chk("B_ptr_valid", core_in_valid, 1);
        chk("B_ptr_ready", ch_in_ready, 0);
        chk("B_ptr_data",  core_in_data, 16'h3333);
        ch_in_valid = 0; core_in_ready = 1;
        tick();
        for (int k = 0; k < 3; k++) begin
            core_out_valid = 1; core_out_data = 16'(16'h1234 + k);
            #1;
            chk("B_out_valid", ch_out_valid, 4'b0100);
            chk("B_out_data",  ch_out_data, 16'h1234 + k);
            tick();
        end
        core_out_valid = 0;
        #1;
        chk("B_empty", sts_inflight, 0);

        // C: fill FIFO to 8 with no returns (grants start at ch3)
        ch_in_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("C_grant", ch_in_ready, 1 << ((3 + k) % 4));
            tick();
        end
        #1;
        chk("C_full_valid",    core_in_valid, 0);
        chk("C_full_ready",    ch_in_ready, 0);
        chk("C_full_inflight", sts_inflight, 8);
        core_out_valid = 1; core_out_data = 16'h0C0C;
        #1;
        chk("C_pop_tag",       ch_out_valid, 4'b1000);
        chk("C_no_bypass",     core_in_valid, 0);
        tick();
        core_out_valid = 0;
        #1;
        chk("C_resume_cnt",    sts_inflight, 7);
        chk("C_resume_valid",  core_in_valid, 1);
        chk("C_resume_grant",  ch_in_ready, 4'b1000);
        tick();
        // FIFO tags now 0,1,2,3,0,1,2,3

        // E: output backpressure on head tag 1
        ch_in_valid = 0; core_out_valid = 1;
        #1;
        chk("E_head0", ch_out_valid, 4'b0001);
        tick();
        ch_out_ready = 4'b1101;
        #1;
        chk("E_stall_cordy", core_out_ready, 0);
        chk("E_stall_valid", ch_out_valid, 4'b0010);
        tick();
        #1;
        chk("E_stall_cnt", sts_inflight, 7);
        ch_out_ready = 4'hF;
        #1;
        chk("E_release", core_out_ready, 1);
        tick();
        #1;
        chk("E_pop_cnt", sts_inflight, 6);
        chk("E_head2",   ch_out_valid, 4'b0100);
        tick();
        #1;
        chk("E_head3",   ch_out_valid, 4'b1000);
        tick();
        core_out_valid = 0;

        // D: halt in the same cycle as a grant, then drain 5
        for (int i = 0; i < 4; i++) ch_in_data[i*16 +: 16] = 16'(16'hD000 + i);
        ch_in_valid = 4'hF; cfg_halt = 1;
        #1;
        chk("D_last_grant", ch_in_ready, 4'b0001);
        tick();
        #1;
        chk("D_no_issue",   core_in_valid, 0);
        chk("D_no_ready",   ch_in_ready, 0);
        chk("D_inflight",   sts_inflight, 5);
        chk("D_not_halted", sts_halted, 0);
        for (int k = 0; k < 5; k++) begin
            core_out_valid = 1;
            #1;
            chk("D_pop_tag",   ch_out_valid, 1 << (k % 4));
            chk("D_pop_noiss", core_in_valid, 0);
            tick();
        end
        core_out_valid = 0;
        #1;
        chk("D_drained_cnt", sts_inflight, 0);
        chk("D_drain_state", sts_halted, 0);
        tick();
        #1;
        chk("D_halted",      sts_halted, 1);
        cfg_halt = 0;
        tick();
        core_in_ready = 0;
        #1;
        chk("D_run_halted",  sts_halted, 0);
        chk("D_run_valid",   core_in_valid, 1);
        chk("D_run_data",    core_in_data, 16'hD001);

        // F: orphan result
        ch_in_valid = 0; core_in_ready = 1;
        core_out_valid = 1; core_out_data = 16'hBEEF;
        #1;
        chk("F_no_route",   ch_out_valid, 0);
        chk("F_no_data",    ch_out_data, 0);
        chk("F_cordy",      core_out_ready, 1);
        chk("F_pre_orphan", err_orphan, 0);
        tick();
        core_out_valid = 0;
        #1;
        chk("F_orphan", err_orphan, 1);
        tick(); tick();
        chk("F_sticky", err_orphan, 1);

        // enable drop: IDLE next cycle, FIFO retained
        ch_in_valid = 4'hF; cfg_enable = 0;
        #1;
        chk("G_still_run", core_in_valid, 1);
        tick();
        #1;
        chk("G_idle",      core_in_valid, 0);
        chk("G_retained",  sts_inflight, 1);

        rst = 1;
        tick();
        rst = 0;
        #1;
        chk("R_orphan_clr", err_orphan, 0);
        chk("R_fifo_clr",   sts_inflight, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
